// File: rtl/calc_frame_rx.sv
`timescale 1ns/1ps
// calc_frame_rx: assembles UART bytes into an {A, B, OP} command frame and
// presents it through a valid/ready output slot. The frame is big-endian per
// word, and an inter-byte timeout resynchronises the framer. Defining
// CALC_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte (13-byte frames).
module calc_frame_rx #(
    parameter int TIMEOUT_CYCLES = 10400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    output logic [3:0]  cmd_op,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        err_checksum,
    output logic [3:0]  byte_count
);
`ifdef CALC_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 13;
`else
    localparam int FRAME_LEN = 12;
`endif
    localparam int            IW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic {RECV, CHECK} state_t;

    state_t        state, state_next;
    logic [95:0]   shreg;
    logic [IW-1:0] idle_cnt;
    logic          last_byte, shift_en, timeout_hit, chk_bad;
    logic          load, overrun;

    // A strobe in the expiry cycle takes priority over the timeout.
    assign last_byte   = byte_valid && (byte_count == LAST_IDX);
    assign timeout_hit = (byte_count != 4'd0) && !byte_valid && (idle_cnt == IDLE_MAX);

`ifdef CALC_FRAME_CHECKSUM_EN
    logic [7:0] xor_acc;

    // The checksum byte is compared, never shifted into the operand register.
    assign shift_en = byte_valid && !last_byte;

    // Running XOR of bytes 0..11; the verdict is latched when byte 12 arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= 8'd0;
            chk_bad <= 1'b0;
        end else if (byte_valid) begin
            if (last_byte)
                chk_bad <= (xor_acc != byte_in);
            else if (byte_count == 4'd0)
                xor_acc <= byte_in;
            else
                xor_acc <= xor_acc ^ byte_in;
        end
    end

    // Checksum error pulse, one cycle after CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_checksum <= 1'b0;
        else        err_checksum <= (state == CHECK) && chk_bad;
    end
`else
    assign shift_en     = byte_valid;
    assign chk_bad      = 1'b0;
    assign err_checksum = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RECV;
        else        state <= state_next;
    end

    // Next state plus the CHECK-cycle decision: load the slot, or drop the frame.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        overrun    = 1'b0;
        case (state)
            RECV:    if (last_byte) state_next = CHECK;
            CHECK: begin
                state_next = RECV;
                if (!chk_bad) begin
                    if (!cmd_valid || cmd_ready) load    = 1'b1;
                    else                         overrun = 1'b1;
                end
            end
            default: state_next = RECV;
        endcase
    end

    // Byte counter, shift register and inter-byte idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= 4'd0;
            shreg      <= 96'd0;
            idle_cnt   <= '0;
        end else begin
            if (shift_en) shreg <= {shreg[87:0], byte_in};
            if (byte_valid) begin
                byte_count <= last_byte ? 4'd0 : 4'(byte_count + 4'd1);
                idle_cnt   <= '0;
            end else if (byte_count == 4'd0 || timeout_hit) begin
                if (timeout_hit) byte_count <= 4'd0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // Output slot: a CHECK reload wins over clearing on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_a     <= 32'd0;
            cmd_b     <= 32'd0;
            cmd_op    <= 4'd0;
            cmd_valid <= 1'b0;
        end else if (load) begin
            cmd_a     <= shreg[95:64];
            cmd_b     <= shreg[63:32];
            cmd_op    <= shreg[3:0];
            cmd_valid <= 1'b1;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Single-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            err_overrun <= overrun;
        end
    end
endmodule

// File: tb/tb_calc_frame_rx.sv
`timescale 1ns/1ps
// Bench for calc_frame_rx: directed frame table, hand-written corner sequences,
// then random traffic against a queue-based frame model.
module tb_calc_frame_rx;
    localparam int T = 30;
`ifdef CALC_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 13;
`else
    localparam int FRAME_LEN = 12;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0, cmd_ready = 1'b0;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_op, byte_count;
    logic        cmd_valid, err_timeout, err_overrun, err_checksum;

    calc_frame_rx #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .err_checksum(err_checksum), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_to = 0, n_ov = 0, n_ck = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frames as byte queues ----------------
    logic [7:0]  q[$];
    logic [7:0]  pend_f[$];
    bit          pend = 0;
    int          idle = 0;
    bit          m_valid = 0, m_to = 0, m_ov = 0, m_ck = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [3:0]  m_op = 0;

    function automatic bit frame_ok(input logic [7:0] f[$]);
`ifdef CALC_FRAME_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        for (int i = 0; i < 12; i++) x ^= f[i];
        return x == f[12];
`else
        return f.size() == 12;
`endif
    endfunction

    // Model advances on each clock using the inputs seen at that edge.
    always @(posedge clk or negedge rst_n) begin
        bit nv;
        if (!rst_n) begin
            q.delete(); pend = 0; idle = 0;
            m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_to = 0; m_ov = 0; m_ck = 0;
        end else begin
            nv = m_valid && !cmd_ready;
            m_to = 0; m_ov = 0; m_ck = 0;
            if (pend) begin
                if (!frame_ok(pend_f)) m_ck = 1;
                else if (!m_valid || cmd_ready) begin
                    nv   = 1;
                    m_a  = {pend_f[0], pend_f[1], pend_f[2], pend_f[3]};
                    m_b  = {pend_f[4], pend_f[5], pend_f[6], pend_f[7]};
                    m_op = pend_f[11][3:0];
                end else m_ov = 1;
                pend = 0;
            end
            m_valid = nv;
            if (byte_valid) begin
                q.push_back(byte_in);
                idle = 0;
                if (q.size() == FRAME_LEN) begin
                    pend_f = q; q.delete(); pend = 1;
                end
            end else if (q.size() != 0) begin
                if (idle == T) begin q.delete(); idle = 0; m_to = 1; end
                else idle++;
            end
        end
    end

    // Every cycle: compare DUT against model and count error pulses.
    always @(negedge clk) begin
        chk("valid", {31'd0, cmd_valid}, {31'd0, m_valid});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
        chk("err_overrun", {31'd0, err_overrun}, {31'd0, m_ov});
        chk("err_checksum", {31'd0, err_checksum}, {31'd0, m_ck});
        chk("byte_count", {28'd0, byte_count}, q.size());
        if (m_valid) begin
            chk("cmd_a", cmd_a, m_a);
            chk("cmd_b", cmd_b, m_b);
            chk("cmd_op", {28'd0, cmd_op}, {28'd0, m_op});
        end
        if (err_timeout)  n_to++;
        if (err_overrun)  n_ov++;
        if (err_checksum) n_ck++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        byte_in = b; byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    // Sends a frame; returns #1 after the edge sampling its final byte (CHECK cycle).
    task automatic send_frame(input logic [95:0] fr, input bit bad_ck);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < 12; i++) begin
            send_byte(fr[95-8*i -: 8]);
            x ^= fr[95-8*i -: 8];
        end
`ifdef CALC_FRAME_CHECKSUM_EN
        send_byte(bad_ck ? (x ^ 8'h01) : x);
`else
        if (bad_ck) x = 8'd0;
`endif
    endtask

    typedef struct {
        logic [95:0] fr;
        logic [31:0] a, b;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs[4];
    logic [95:0] f1, f2;
    int to0, ov0, ck0;

    initial begin
        vecs[0] = '{96'h00000007_00000005_00000002, 32'h7, 32'h5, 4'h2};
        vecs[1] = '{96'hDEADBEEF_01020304_FFFFFFFA, 32'hDEADBEEF, 32'h01020304, 4'hA};
        vecs[2] = '{96'hFFFFFFFF_00000000_123456F0, 32'hFFFFFFFF, 32'h0, 4'h0};
        vecs[3] = '{96'h80000001_7FFFFFFE_0000000F, 32'h80000001, 32'h7FFFFFFE, 4'hF};

        // Reset state
        #12;
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_a", cmd_a, 32'd0);
        chk("rst_b", cmd_b, 32'd0);
        chk("rst_op", {28'd0, cmd_op}, 32'd0);
        chk("rst_count", {28'd0, byte_count}, 32'd0);
        chk("rst_errs", {29'd0, err_timeout, err_overrun, err_checksum}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Table: frames with the consumer always ready
        cmd_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].fr, 1'b0);
            @(negedge clk);
            chk("tbl_valid_n1", {31'd0, cmd_valid}, 32'd0);
            @(negedge clk);
            chk("tbl_valid_n2", {31'd0, cmd_valid}, 32'd1);
            chk("tbl_a", cmd_a, vecs[v].a);
            chk("tbl_b", cmd_b, vecs[v].b);
            chk("tbl_op", {28'd0, cmd_op}, {28'd0, vecs[v].op});
            @(negedge clk);
            chk("tbl_valid_n3", {31'd0, cmd_valid}, 32'd0);
        end

        // Timeout: partial frame discarded, next frame decodes
        to0 = n_to;
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        repeat (T + 10) @(negedge clk);
        chk("to_pulses", n_to - to0, 32'd1);
        chk("to_count", {28'd0, byte_count}, 32'd0);
        send_frame(vecs[1].fr, 1'b0);
        repeat (2) @(negedge clk);
        chk("to_next_valid", {31'd0, cmd_valid}, 32'd1);
        chk("to_next_a", cmd_a, 32'hDEADBEEF);
        chk("to_next_op", {28'd0, cmd_op}, 32'hA);
        @(negedge clk);

        // Overrun: second frame dropped, first held
        cmd_ready = 1'b0;
        ov0 = n_ov;
        f1 = 96'h11111111_22222222_00000003;
        f2 = 96'h33333333_44444444_00000004;
        send_frame(f1, 1'b0);
        send_frame(f2, 1'b0);
        repeat (3) @(negedge clk);
        chk("ov_pulses", n_ov - ov0, 32'd1);
        chk("ov_valid", {31'd0, cmd_valid}, 32'd1);
        chk("ov_a", cmd_a, 32'h11111111);
        chk("ov_b", cmd_b, 32'h22222222);
        chk("ov_op", {28'd0, cmd_op}, 32'h3);
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(negedge clk);
        chk("ov_accept_a", cmd_a, 32'h11111111);
        chk("ov_accept_op", {28'd0, cmd_op}, 32'h3);
        @(negedge clk);
        chk("ov_drained", {31'd0, cmd_valid}, 32'd0);

        // Simultaneous: ready pulses in the CHECK cycle of frame 2
        cmd_ready = 1'b0;
        ov0 = n_ov;
        send_frame(f1, 1'b0);
        repeat (2) @(negedge clk);
        send_frame(f2, 1'b0);
        cmd_ready = 1'b1;
        @(posedge clk); #1 cmd_ready = 1'b0;
        @(negedge clk);
        chk("sim_valid", {31'd0, cmd_valid}, 32'd1);
        chk("sim_a", cmd_a, 32'h33333333);
        chk("sim_op", {28'd0, cmd_op}, 32'h4);
        repeat (2) @(negedge clk);
        chk("sim_no_ov", n_ov - ov0, 32'd0);
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);

`ifdef CALC_FRAME_CHECKSUM_EN
        // Checksum good and bad
        ck0 = n_ck;
        send_frame(vecs[1].fr, 1'b0);
        repeat (2) @(negedge clk);
        chk("ck_good_valid", {31'd0, cmd_valid}, 32'd1);
        @(negedge clk);
        send_frame(vecs[1].fr, 1'b1);
        repeat (3) @(negedge clk);
        chk("ck_bad_pulse", n_ck - ck0, 32'd1);
        chk("ck_bad_valid", {31'd0, cmd_valid}, 32'd0);
`else
        ck0 = n_ck;
`endif

        // Asynchronous reset mid-frame with a pending command
        cmd_ready = 1'b0;
        send_frame(f1, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'hA0);
        to0 = n_to; ov0 = n_ov;
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mrst_count", {28'd0, byte_count}, 32'd0);
        chk("mrst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("mrst_a", cmd_a, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (T + 5) @(negedge clk);
        chk("mrst_no_err", (n_to - to0) + (n_ov - ov0), 32'd0);

        // Random traffic, with periodic quiet gaps long enough to time out
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            byte_valid = ((c % 400) < 360) && ($urandom_range(3) == 0);
            byte_in    = 8'($urandom);
            cmd_ready  = ($urandom_range(2) != 0);
        end
        @(posedge clk); #1 byte_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
